// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: two-flop input synchroniser, centre sampling, stop-bit check,
// and a one-entry valid/ready output register with frame-error and overrun pulses.
module uart_rx_frame #(
   parameter int unsigned CLK_FREQ     = 10000000,
   parameter int unsigned BAUD_RATE    = 115200,
   parameter int unsigned SYMBOL_COUNT = CLK_FREQ / BAUD_RATE,
   parameter int unsigned HALF_COUNT   = SYMBOL_COUNT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [31:0] SYM_LAST  = 32'(SYMBOL_COUNT - 1);
   localparam logic [31:0] HALF_LAST = 32'(HALF_COUNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state_q;
   logic        rx_meta_q;
   logic        rx_s_q;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   logic [2:0]  bit_idx_q;
   logic [2:0]  bit_idx_d;
   logic [7:0]  shift_q;
   logic [7:0]  shift_d;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q;
   logic        frame_err_q;
   logic        overrun_q;
   logic        can_deliver;

   assign cnt_d       = cnt_q + 32'd1;
   assign bit_idx_d   = bit_idx_q + 3'd1;
   assign shift_d     = {rx_s_q, shift_q[7:1]};
   // The held byte may be replaced on the very edge it is being accepted.
   assign can_deliver = !rx_valid_q || rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DATA: begin
               if (cnt_q == SYM_LAST) begin
                  cnt_q     <= '0;
                  shift_q   <= shift_d;
                  bit_idx_q <= bit_idx_d;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STOP: begin
               if (cnt_q == SYM_LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= IDLE;
                     if (can_deliver) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     // Line still low: wait for idle so a break is not seen as a start bit.
                     state_q     <= WAIT_HIGH;
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            WAIT_HIGH: begin
               if (rx_s_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of frames plus hand-written glitch,
// framing-error, overrun and mid-frame reset sequences.
module tb_uart_rx_frame;

   localparam int BIT_CYC = 86;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_frame dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int         n_total = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         fall_cyc = 0;
   int         rise_cyc = 0;
   int         valid_hi = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   int         both_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] rx_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && !prev_valid) rise_cyc = cyc;
         if (rx_valid) valid_hi++;
         if (rx_valid && rx_ready) rx_q.push_back(rx_data);
         if (frame_err) ferr_cnt++;
         if (overrun) ovr_cnt++;
         if (frame_err && overrun) both_cnt++;
      end
      prev_valid = rx_valid;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_total++;
      if (got >= lo && got <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
   endtask

   // Drives one frame; with release_line=0 the line is left at the stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic release_line);
      @(posedge clk); #1 rx = 1'b0; fall_cyc = cyc;
      repeat (BIT_CYC) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = d[i];
         repeat (BIT_CYC) @(posedge clk);
      end
      #1 rx = stop;
      repeat (BIT_CYC) @(posedge clk);
      if (release_line) #1 rx = 1'b1;
   endtask

   task automatic expect_byte(input string name, input logic [7:0] exp);
      check({name, "_count"}, rx_q.size(), 1);
      if (rx_q.size() > 0) check(name, rx_q.pop_front(), exp);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_count;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int ferr0;
      int ovr0;
      int vh0;
      int q0;

      vecs[0]  = '{8'h50, 1'b1, 1, 8'h50, 0};
      vecs[1]  = '{8'h68, 1'b1, 1, 8'h68, 0};
      vecs[2]  = '{8'h69, 1'b1, 1, 8'h69, 0};
      vecs[3]  = '{8'h6C, 1'b1, 1, 8'h6C, 0};
      vecs[4]  = '{8'h69, 1'b1, 1, 8'h69, 0};
      vecs[5]  = '{8'h70, 1'b1, 1, 8'h70, 0};
      vecs[6]  = '{8'h20, 1'b1, 1, 8'h20, 0};
      vecs[7]  = '{8'h4D, 1'b1, 1, 8'h4D, 0};
      vecs[8]  = '{8'h6F, 1'b1, 1, 8'h6F, 0};
      vecs[9]  = '{8'h68, 1'b1, 1, 8'h68, 0};
      vecs[10] = '{8'h72, 1'b1, 1, 8'h72, 0};
      vecs[11] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[12] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[13] = '{8'h81, 1'b0, 0, 8'h00, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      repeat (10) @(posedge clk);

      // Single byte with latency and one-cycle valid pulse
      rx_ready = 1'b1;
      vh0 = valid_hi;
      send_frame(8'h50, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check_range("latency", rise_cyc - fall_cyc, 818, 822);
      check("single_valid_cycles", valid_hi - vh0, 1);
      check("single_rx_valid_after", rx_valid, 0);
      expect_byte("single_data", 8'h50);

      // Table: "Philip Mohr", boundary bytes, bad stop bit
      for (int i = 0; i < 14; i++) begin
         ferr0 = ferr_cnt;
         send_frame(vecs[i].data, vecs[i].stop, 1'b1);
         repeat (8) @(posedge clk);
         #1;
         check($sformatf("vec%0d_count", i), rx_q.size(), vecs[i].exp_count);
         if (vecs[i].exp_count > 0 && rx_q.size() > 0)
            check($sformatf("vec%0d_data", i), rx_q.pop_front(), vecs[i].exp_data);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - ferr0, vecs[i].exp_ferr);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end
      check("table_no_overrun", ovr_cnt, 0);

      // Glitch on the start bit
      ferr0 = ferr_cnt;
      q0 = rx_q.size();
      @(posedge clk); #1 rx = 1'b0;
      repeat (10) @(posedge clk);
      #1 check("glitch_busy_high", busy, 1);
      repeat (10) @(posedge clk);
      #1 rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_busy_low", busy, 0);
      check("glitch_no_byte", rx_q.size() - q0, 0);
      check("glitch_rx_valid", rx_valid, 0);
      check("glitch_no_ferr", ferr_cnt - ferr0, 0);

      // Framing error followed by a long low line
      ferr0 = ferr_cnt;
      send_frame(8'hA5, 1'b0, 1'b0);
      repeat (300) @(posedge clk);
      #1;
      check("ferr_pulses", ferr_cnt - ferr0, 1);
      check("ferr_wait_high_busy", busy, 1);
      check("ferr_no_byte", rx_q.size(), 0);
      rx = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("ferr_idle_after_high", busy, 0);
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      expect_byte("after_ferr_data", 8'h3C);

      // Overrun: consumer stalled across two frames
      rx_ready = 1'b0;
      ovr0 = ovr_cnt;
      send_frame(8'h41, 1'b1, 1'b1);
      #1;
      check("ovr_first_no_pulse", ovr_cnt - ovr0, 0);
      send_frame(8'h42, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("ovr_pulses", ovr_cnt - ovr0, 1);
      check("ovr_rx_valid", rx_valid, 1);
      check("ovr_rx_data", rx_data, 8'h41);
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
      check("ovr_valid_dropped", rx_valid, 0);
      expect_byte("ovr_accepted", 8'h41);

      // Reset during bit 4 of 0x55 while a byte is held
      send_frame(8'h33, 1'b1, 1'b1);
      #1 check("held_before_rst", rx_valid, 1);
      @(posedge clk); #1 rx = 1'b0;
      repeat (BIT_CYC) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #1 rx = (i % 2 == 0);
         repeat (BIT_CYC) @(posedge clk);
      end
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_rx_data", rx_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_overrun", overrun, 0);
      rx_ready = 1'b1;
      repeat (600) @(posedge clk);
      #1 check("midrst_no_byte", rx_q.size(), 0);
      send_frame(8'h55, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      expect_byte("after_rst_data", 8'h55);

      check("never_both_pulses", both_cnt, 0);
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
